// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM encodings, block geometry
// and the byte-level InvSubBytes / InvMixColumns helpers.
package aes_inv_cipher_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    // Entry i sits at bits [2047-8*i -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns coefficients 09/0b/0d/0e (bit 3 always set).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [31:0] res;
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            res[31 - 8*r -: 8] = gmul(col[31 - 8*r -: 8], 4'he)
                               ^ gmul(col[31 - 8*((r + 1) % 4) -: 8], 4'hb)
                               ^ gmul(col[31 - 8*((r + 2) % 4) -: 8], 4'hd)
                               ^ gmul(col[31 - 8*((r + 3) % 4) -: 8], 4'h9);
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++)
            res[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_inv_cipher_ctrl_pkg::*;
(
    input  logic [AES_BLK_W-1:0] st,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] nxt
);

    logic [AES_BLK_W-1:0] sb;
    logic [AES_BLK_W-1:0] ark;

    // Byte (r,c) lives at index r+4c; InvShiftRows takes row r from column c-r.
    always_comb begin
        sb = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sb[127 - 8*(r + 4*c) -: 8] =
                    inv_sub_byte(st[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
            end
        end
        ark = sb ^ rk;
        nxt = last ? ark : inv_mix_columns(ark);
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller, one inverse round per clock.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_inv_cipher_ctrl
    import aes_inv_cipher_ctrl_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic [3:0]           rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    logic [1:0]           state;
    logic [3:0]           rnd;
    logic [AES_BLK_W-1:0] st;
    logic [AES_BLK_W-1:0] round_out;
    logic                 abort_req;

`ifdef AES_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    aes_inv_round u_round (
        .st   (st),
        .rk   (rk_data),
        .last (state == S_FINAL),
        .nxt  (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            st    <= '0;
            rnd   <= '0;
        end else if (abort_req) begin
            state <= S_IDLE;
            st    <= '0;
            rnd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st    <= in_data ^ rk_data;
                        rnd   <= 4'(NR - 1);
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st  <= round_out;
                    rnd <= rnd - 4'd1;
                    if (rnd == 4'd1)
                        state <= S_FINAL;
                end
                S_FINAL: begin
                    st    <= round_out;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rk_idx = 4'(NR);
        case (state)
            S_ROUND: rk_idx = rnd;
            S_FINAL: rk_idx = 4'd0;
            default: rk_idx = 4'(NR);
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_data  = st;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl using the FIPS-197 C.1 AES-128 vector.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_ALT = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         abort;

    int checks = 0;
    int errors = 0;

    logic [127:0] rk_tab [16];

    always #5 clk = ~clk;

    // Key-expansion store for key 000102030405060708090a0b0c0d0e0f.
    assign rk_data = rk_tab[rk_idx];

    aes_inv_cipher_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"},  out_data,        128'(0));
        check({tag, "_busy"},      128'(busy),      128'(0));
        check({tag, "_rk_idx"},    128'(rk_idx),    128'(10));
    endtask

    task automatic check_idle_kept(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_busy"},      128'(busy),      128'(0));
        check({tag, "_rk_idx"},    128'(rk_idx),    128'(10));
    endtask

    // Presents a block in IDLE; returns at the negedge after the accept edge.
    task automatic start_block(input logic [127:0] ct);
        @(negedge clk);
        check("accept_in_ready", 128'(in_ready), 128'(1));
        check("accept_rk_idx",   128'(rk_idx),   128'(10));
        in_valid = 1'b1;
        in_data  = ct;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic trace_rounds(input bit inject);
        for (int k = 9; k >= 1; k--) begin
            check($sformatf("round%0d_rk_idx", k),    128'(rk_idx),    128'(k));
            check($sformatf("round%0d_out_valid", k), 128'(out_valid), 128'(0));
            check($sformatf("round%0d_in_ready", k),  128'(in_ready),  128'(0));
            in_valid = inject && (k == 6 || k == 5);
            in_data  = CT_ALT;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("final_rk_idx",    128'(rk_idx),    128'(0));
        check("final_out_valid", 128'(out_valid), 128'(0));
        check("final_busy",      128'(busy),      128'(1));
        @(negedge clk);
    endtask

    task automatic drain(input int hold);
        for (int h = 0; h < hold; h++) begin
            check("hold_out_valid", 128'(out_valid), 128'(1));
            check("hold_out_data",  out_data,        PT);
            check("hold_in_ready",  128'(in_ready),  128'(0));
            check("hold_busy",      128'(busy),      128'(1));
            @(negedge clk);
        end
        check("done_out_valid", 128'(out_valid), 128'(1));
        check("done_out_data",  out_data,        PT);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle_kept("after_done");
    endtask

    task automatic quiet(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check(tag, 128'(seen), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;
        rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        abort     = 1'b0;
        #2;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain C.1 decryption with exact latency and rk_idx trace.
        start_block(CT);
        trace_rounds(1'b0);
        drain(0);

        // Backpressure in DONE and an ignored in_valid pulse during ROUND.
        start_block(CT);
        trace_rounds(1'b1);
        drain(5);
        quiet(15, "no_second_result");

        // Asynchronous reset while rnd=5.
        start_block(CT);
        repeat (4) @(negedge clk);
        check("pre_reset_rk_idx", 128'(rk_idx), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        check_idle("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        quiet(3, "reset_no_output");
        start_block(CT);
        trace_rounds(1'b0);
        drain(1);

`ifdef AES_CTRL_ABORT_EN
        // Abort while rnd=3, then a clean block.
        start_block(CT);
        repeat (6) @(negedge clk);
        check("pre_abort_rk_idx", 128'(rk_idx), 128'(3));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_round");
        quiet(12, "abort_no_output");
        start_block(CT);
        trace_rounds(1'b0);
        drain(0);

        // Abort wins over out_ready in DONE; the result is dropped.
        start_block(CT);
        trace_rounds(1'b0);
        check("pre_abort_done_valid", 128'(out_valid), 128'(1));
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check_idle("abort_done");
        quiet(5, "abort_done_no_output");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
